reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 162 ++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Arbitrates the register file's single write port between pipeline writeback and
// mul/div results, with starvation-bounded priority and a pending-register scoreboard.
module reg_write_arbiter (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WB_VALID,
    input  logic [4:0]  WB_ADDR,
    input  logic [31:0] WB_DATA,
    output logic        WB_READY,
    input  logic        MD_VALID,
    input  logic [4:0]  MD_ADDR,
    input  logic [31:0] MD_DATA,
    output logic        MD_READY,
    input  logic        MD_ISSUE,
    input  logic [4:0]  MD_ISSUE_ADDR,
    output logic        ISSUE_READY,
    input  logic [4:0]  RS1_ADDR,
    input  logic [4:0]  RS2_ADDR,
    output logic        STALL,
    output logic        WRITE,
    output logic [4:0]  INADDRESS,
    output logic [31:0] IN
);

    typedef enum logic [0:0] {WB_PRI = 1'b0, MD_PRI = 1'b1} pri_e;

    pri_e        state_r;
    pri_e        state_next_s;
    logic [1:0]  starve_r;
    logic [1:0]  starve_next_s;
    logic        wb_grant_s;
    logic        md_grant_s;
    logic [31:0] pending_r;
    logic [31:0] pending_next_s;
    logic [31:0] set_mask_s;
    logic [31:0] clr_mask_s;
    logic        issue_set_s;

    // Priority state register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r <= WB_PRI;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Starvation counter next value: counts cycles MD is left waiting
    always_comb begin
        starve_next_s = 2'd0;
        if (MD_VALID && !md_grant_s) begin
            if (starve_r != 2'd3) begin
                starve_next_s = starve_r + 2'd1;
            end else begin
                starve_next_s = starve_r;
            end
        end else begin
            starve_next_s = 2'd0;
        end
    end

    // Starvation counter register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            starve_r <= 2'd0;
        end else begin
            starve_r <= starve_next_s;
        end
    end

    // Next-state logic: promote MD once it has waited two cycles, demote after its grant
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            WB_PRI: begin
                if (starve_next_s == 2'd2) begin
                    state_next_s = MD_PRI;
                end else begin
                    state_next_s = WB_PRI;
                end
            end
            MD_PRI: begin
                if (md_grant_s) begin
                    state_next_s = WB_PRI;
                end else begin
                    state_next_s = MD_PRI;
                end
            end
            default: state_next_s = WB_PRI;
        endcase
    end

    // Grant outputs; nothing is granted while reset is held
    always_comb begin
        wb_grant_s = 1'b0;
        md_grant_s = 1'b0;
        if (!RESET) begin
            wb_grant_s = 1'b0;
            md_grant_s = 1'b0;
        end else begin
            case (state_r)
                WB_PRI: begin
                    wb_grant_s = WB_VALID;
                    md_grant_s = MD_VALID && !WB_VALID;
                end
                MD_PRI: begin
                    md_grant_s = MD_VALID;
                    wb_grant_s = WB_VALID && !MD_VALID;
                end
                default: begin
                    wb_grant_s = 1'b0;
                    md_grant_s = 1'b0;
                end
            endcase
        end
    end

    assign WB_READY = wb_grant_s;
    assign MD_READY = md_grant_s;

    // Registered write port; x0 targets are accepted but never written
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            WRITE     <= 1'b0;
            INADDRESS <= 5'd0;
            IN        <= 32'd0;
        end else if (wb_grant_s) begin
            WRITE     <= (WB_ADDR != 5'd0);
            INADDRESS <= WB_ADDR;
            IN        <= WB_DATA;
        end else if (md_grant_s) begin
            WRITE     <= (MD_ADDR != 5'd0);
            INADDRESS <= MD_ADDR;
            IN        <= MD_DATA;
        end else begin
            WRITE     <= 1'b0;
        end
    end

    // A clear on the same register this cycle frees the slot for a new issue
    assign ISSUE_READY = !(pending_r[MD_ISSUE_ADDR] &&
                           !(md_grant_s && (MD_ADDR == MD_ISSUE_ADDR)));
    assign issue_set_s = RESET && MD_ISSUE && ISSUE_READY && (MD_ISSUE_ADDR != 5'd0);
    assign set_mask_s  = issue_set_s ? (32'd1 << MD_ISSUE_ADDR) : 32'd0;
    assign clr_mask_s  = md_grant_s  ? (32'd1 << MD_ADDR)       : 32'd0;

    // Set is applied after clear so it wins on a same-register collision
    assign pending_next_s = ((pending_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;

    // Pending scoreboard register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pending_r <= 32'd0;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign STALL = (pending_r[RS1_ADDR] && (RS1_ADDR != 5'd0)) ||
                   (pending_r[RS2_ADDR] && (RS2_ADDR != 5'd0));

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: stimulus queues expected register-file
// writes, a negedge monitor pops and compares them against the write port.
module tb_reg_write_arbiter;

    logic        CLK;
    logic        RESET;
    logic        WB_VALID;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA;
    logic        WB_READY;
    logic        MD_VALID;
    logic [4:0]  MD_ADDR;
    logic [31:0] MD_DATA;
    logic        MD_READY;
    logic        MD_ISSUE;
    logic [4:0]  MD_ISSUE_ADDR;
    logic        ISSUE_READY;
    logic [4:0]  RS1_ADDR;
    logic [4:0]  RS2_ADDR;
    logic        STALL;
    logic        WRITE;
    logic [4:0]  INADDRESS;
    logic [31:0] IN;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;

    reg_write_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .WB_READY(WB_READY),
        .MD_VALID(MD_VALID), .MD_ADDR(MD_ADDR), .MD_DATA(MD_DATA), .MD_READY(MD_READY),
        .MD_ISSUE(MD_ISSUE), .MD_ISSUE_ADDR(MD_ISSUE_ADDR), .ISSUE_READY(ISSUE_READY),
        .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR), .STALL(STALL),
        .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_write(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{cyc + 1, a, d});
    endtask

    // Drive one cycle of inputs just after the edge; combinational outputs settle by return
    task automatic step(input logic rst,
                        input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                        input logic mdv, input logic [4:0] mda, input logic [31:0] mdd,
                        input logic iss, input logic [4:0] issa,
                        input logic [4:0] r1, input logic [4:0] r2);
        @(posedge CLK);
        #1;
        RESET = rst;
        WB_VALID = wbv; WB_ADDR = wba; WB_DATA = wbd;
        MD_VALID = mdv; MD_ADDR = mda; MD_DATA = mdd;
        MD_ISSUE = iss; MD_ISSUE_ADDR = issa;
        RS1_ADDR = r1;  RS2_ADDR = r2;
        #1;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r1, r2);
    endtask

    // Write-port monitor
    always @(negedge CLK) begin
        if (WRITE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("write_cycle", cyc, e.cyc);
                check("write_addr", {27'd0, INADDRESS}, {27'd0, e.addr});
                check("write_data", IN, e.data);
            end
        end
    end

    initial begin
        RESET = 1'b0;
        WB_VALID = 1'b0; WB_ADDR = 5'd0; WB_DATA = 32'd0;
        MD_VALID = 1'b0; MD_ADDR = 5'd0; MD_DATA = 32'd0;
        MD_ISSUE = 1'b0; MD_ISSUE_ADDR = 5'd0;
        RS1_ADDR = 5'd0; RS2_ADDR = 5'd0;

        // Reset: requests are refused
        step(1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b1, 5'd6, 5'd6, 5'd0);
        check("rst_wb_ready", {31'd0, WB_READY}, 32'd0);
        check("rst_md_ready", {31'd0, MD_READY}, 32'd0);
        step(1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b1, 5'd6, 5'd6, 5'd0);
        idle(5'd6, 5'd4);
        check("rst_write", {31'd0, WRITE}, 32'd0);
        check("rst_inaddress", {27'd0, INADDRESS}, 32'd0);
        check("rst_in", IN, 32'd0);
        check("rst_stall", {31'd0, STALL}, 32'd0);

        // Lone writeback request
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("wb_alone_ready", {31'd0, WB_READY}, 32'd1);
        check("wb_alone_md_ready", {31'd0, MD_READY}, 32'd0);
        exp_write(5'd5, 32'hDEADBEEF);
        idle(5'd0, 5'd0);

        // Contention: WB, WB, MD, WB
        step(1'b1, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd7, 32'h12, 1'b0, 5'd0, 5'd0, 5'd0);
        check("arb_c0_wb", {31'd0, WB_READY}, 32'd1);
        check("arb_c0_md", {31'd0, MD_READY}, 32'd0);
        exp_write(5'd10, 32'hA0);
        step(1'b1, 1'b1, 5'd11, 32'hA1, 1'b1, 5'd7, 32'h12, 1'b0, 5'd0, 5'd0, 5'd0);
        check("arb_c1_wb", {31'd0, WB_READY}, 32'd1);
        check("arb_c1_md", {31'd0, MD_READY}, 32'd0);
        exp_write(5'd11, 32'hA1);
        step(1'b1, 1'b1, 5'd12, 32'hA2, 1'b1, 5'd7, 32'h12, 1'b0, 5'd0, 5'd0, 5'd0);
        check("arb_c2_wb", {31'd0, WB_READY}, 32'd0);
        check("arb_c2_md", {31'd0, MD_READY}, 32'd1);
        exp_write(5'd7, 32'h12);
        step(1'b1, 1'b1, 5'd12, 32'hA2, 1'b1, 5'd7, 32'h13, 1'b0, 5'd0, 5'd0, 5'd0);
        check("arb_c3_wb", {31'd0, WB_READY}, 32'd1);
        check("arb_c3_md", {31'd0, MD_READY}, 32'd0);
        exp_write(5'd12, 32'hA2);
        idle(5'd0, 5'd0);

        // Scoreboard: issue, duplicate issue, clear+reissue collision, final clear
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        check("sb_issue_ready", {31'd0, ISSUE_READY}, 32'd1);
        check("sb_stall_same_cycle", {31'd0, STALL}, 32'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        check("sb_dup_issue_ready", {31'd0, ISSUE_READY}, 32'd0);
        check("sb_stall_rs1", {31'd0, STALL}, 32'd1);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9);
        check("sb_stall_rs2", {31'd0, STALL}, 32'd1);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, 5'd0);
        check("sb_collide_md_ready", {31'd0, MD_READY}, 32'd1);
        check("sb_collide_issue_ready", {31'd0, ISSUE_READY}, 32'd1);
        check("sb_collide_stall", {31'd0, STALL}, 32'd1);
        exp_write(5'd9, 32'h99);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd9, 5'd0);
        check("sb_set_wins_stall", {31'd0, STALL}, 32'd1);
        check("sb_set_wins_issue_ready", {31'd0, ISSUE_READY}, 32'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd9, 5'd0);
        check("sb_clear_md_ready", {31'd0, MD_READY}, 32'd1);
        check("sb_clear_stall_still", {31'd0, STALL}, 32'd1);
        exp_write(5'd9, 32'h55);
        idle(5'd9, 5'd0);
        check("sb_cleared_stall", {31'd0, STALL}, 32'd0);

        // x0 handling: accepted but not written; issue to x0 never stalls
        step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        check("x0_wb_ready", {31'd0, WB_READY}, 32'd1);
        check("x0_issue_ready", {31'd0, ISSUE_READY}, 32'd1);
        idle(5'd0, 5'd0);
        check("x0_write", {31'd0, WRITE}, 32'd0);
        check("x0_stall", {31'd0, STALL}, 32'd0);

        // Mid-operation reset with pending bits and MD priority active
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0, 5'd0);
        step(1'b1, 1'b1, 5'd20, 32'hB0, 1'b1, 5'd21, 32'hC1, 1'b0, 5'd0, 5'd3, 5'd12);
        check("pre_rst_stall", {31'd0, STALL}, 32'd1);
        check("pre_rst_wb0", {31'd0, WB_READY}, 32'd1);
        exp_write(5'd20, 32'hB0);
        step(1'b1, 1'b1, 5'd22, 32'hB2, 1'b1, 5'd21, 32'hC1, 1'b0, 5'd0, 5'd3, 5'd12);
        check("pre_rst_wb1", {31'd0, WB_READY}, 32'd1);
        exp_write(5'd22, 32'hB2);
        step(1'b0, 1'b1, 5'd23, 32'hB3, 1'b1, 5'd21, 32'hC1, 1'b1, 5'd5, 5'd3, 5'd12);
        check("mid_rst_wb_ready", {31'd0, WB_READY}, 32'd0);
        check("mid_rst_md_ready", {31'd0, MD_READY}, 32'd0);
        step(1'b1, 1'b1, 5'd23, 32'hB3, 1'b1, 5'd21, 32'hC1, 1'b0, 5'd0, 5'd3, 5'd12);
        check("post_rst_write", {31'd0, WRITE}, 32'd0);
        check("post_rst_inaddress", {27'd0, INADDRESS}, 32'd0);
        check("post_rst_in", IN, 32'd0);
        check("post_rst_stall", {31'd0, STALL}, 32'd0);
        check("post_rst_wb_pri", {31'd0, WB_READY}, 32'd1);
        exp_write(5'd23, 32'hB3);
        step(1'b1, 1'b1, 5'd24, 32'hB4, 1'b1, 5'd21, 32'hC1, 1'b0, 5'd0, 5'd5, 5'd0);
        check("post_rst_ignored_issue", {31'd0, STALL}, 32'd0);
        check("post_rst_wb1", {31'd0, WB_READY}, 32'd1);
        exp_write(5'd24, 32'hB4);
        step(1'b1, 1'b1, 5'd25, 32'hB5, 1'b1, 5'd21, 32'hC1, 1'b0, 5'd0, 5'd0, 5'd0);
        check("post_rst_md2", {31'd0, MD_READY}, 32'd1);
        exp_write(5'd21, 32'hC1);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);
        @(posedge CLK);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
